pixel_writer: RTL and testbench
===============================

# pixel_writer

Downstream consumer of the Julia worker search stage. Takes the selected worker's pixel value and framebuffer address, buffers them in a small FIFO, and issues them as single-beat writes on an Avalon-MM style master port to frame memory. Each accepted pixel is acknowledged with a one-cycle `release` pulse, which lets the search stage advance to the next done worker.

## Interface
- `FIFO_DEPTH`, 4: pixel buffer entries; power of two, ≥ 2.
- `BASE_ADDR`, 32'h0000_0000: framebuffer base added to every incoming address.
- `FRAME_PIXELS`, 307200: pixels per frame (640×480); used only when the frame counter is compiled in.
- `clk` in 1: single clock; all logic rising-edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `found` in 1: search stage has a valid selected pixel; level, held until released.
- `sel_data_syn` in 8: pixel value; valid while `found`=1.
- `sel_address_syn` in 32: pixel address, frame-relative; valid while `found`=1.
- `release` out 1: registered one-cycle pulse; pixel accepted into the FIFO.
- `avm_address` out 32: write address, `BASE_ADDR` + captured address.
- `avm_writedata` out 8: pixel value.
- `avm_write` out 1: write request.
- `avm_waitrequest` in 1: slave stall. A write completes on a rising edge where `avm_write`=1 and `avm_waitrequest`=0.
- `busy` out 1: FIFO non-empty or write in flight.
- `frame_done` out 1: one-cycle pulse on the last pixel write of a frame.

## Operation
- Accept FSM, states ACC_IDLE, ACC_ACK, ACC_SETTLE:
  - ACC_IDLE with `found`=1 and FIFO not full: push {`sel_address_syn`, `sel_data_syn`}, go to ACC_ACK.
  - ACC_ACK: `release`=1, go to ACC_SETTLE.
  - ACC_SETTLE: ignore `found` for one cycle so the registered search outputs can refresh, then return to ACC_IDLE.
  - Maximum rate is one accept per 3 cycles.
- `found`=1 while the FIFO is full: no push, no `release`. Wait in ACC_IDLE.
- A push is blocked whenever the FIFO is full at the edge, even if a pop happens on the same edge. There is no full-bypass.
- Write FSM, states W_IDLE and W_WRITE:
  - W_IDLE with FIFO non-empty: load the head into the `avm_*` registers, set `avm_write`=1, go to W_WRITE.
  - W_WRITE: hold address, data and `avm_write` stable while `avm_waitrequest`=1.
  - On completion, pop the head. If the FIFO still holds an entry after the pop, load it on the same edge and stay in W_WRITE (back-to-back writes). Otherwise clear `avm_write` and go to W_IDLE.
- Address arithmetic is 32-bit modulo 2^32. A carry out of the sum is discarded.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Empty: pointers equal.
  - Full: MSBs differ and the lower bits are equal.
- Simultaneous push and pop when not full: both occur, and the count is unchanged.
- Reset values: `release`=0, `avm_write`=0, `avm_address`=0, `avm_writedata`=0, `busy`=0, `frame_done`=0, FIFO empty, both FSMs in their idle state.
- Reset asserted mid-write: `avm_write` drops asynchronously and buffered pixels are discarded.

## Timing
- `found` sampled high at edge N (FIFO empty, W_IDLE):
  - push at N;
  - `release`=1 and `avm_write`=1 during N+1..N+2;
  - earliest write completion at edge N+2.
- `release` is never high on two consecutive cycles.
- With `avm_waitrequest`=0 and a full FIFO, one write completes per cycle.

## Configuration
- `PIXEL_WRITER_FRAME_COUNT_EN` defined:
  - A counter of width $clog2(FRAME_PIXELS) increments on each completed write.
  - On the completion that takes the count to FRAME_PIXELS−1 → wrap, the counter returns to 0 and `frame_done` pulses for one cycle.
  - Reset clears the counter.
- `PIXEL_WRITER_FRAME_COUNT_EN` undefined: no counter is built and `frame_done` is tied to 0. The port list is the same in both builds.

## Structure
- Shared `julia_pkg` holds:
  - `pixel_t` (logic [7:0]);
  - `addr_t` (logic [31:0]);
  - `acc_state_t` and `wr_state_t` enums.
- One sub-module, `pixel_fifo`:
  - parameterised depth and width;
  - push/pop/full/empty;
  - registered storage, head visible combinationally.
- Both FSMs and the Avalon output registers live in `pixel_writer`.

## Test plan
- Reset, then `found`=1, data 8'hA5, address 32'h10, `BASE_ADDR`=32'h1000, `avm_waitrequest`=0 → `release` pulses at N+1, then one write to 32'h1010 with data 8'hA5, then `busy`=0.
- `found` held high for 10 cycles with the same data → `release` pulses every 3rd cycle, never on consecutive cycles.
- `avm_waitrequest`=1 for 20 cycles while `found` stays high → after 4 accepts no further `release`, and `avm_address`/`avm_writedata` stay stable. Then release the stall → 4 back-to-back writes in FIFO order.
- Address 32'hFFFF_FFFF with `BASE_ADDR`=32'h2 → `avm_address`=32'h1 (wrap).
- Assert `n_rst` while `avm_write`=1 with 3 entries buffered → `avm_write`=0 immediately, no writes after reset, `busy`=0.
- Macro defined, `FRAME_PIXELS`=4, 9 pixels written → `frame_done` pulses after the 4th and 8th completions only.

Source files
------------

// File: rtl/julia_pkg.sv
// rtl/julia_pkg.sv - shared types for the Julia renderer pixel path
// Purpose: pixel/address types, the buffered pixel entry and the FSM state
//          encodings used by pixel_writer and pixel_fifo.
// Ports:   none (package).
package julia_pkg;

  typedef logic [7:0]  pixel_t;
  typedef logic [31:0] addr_t;

  // One buffered pixel: frame-relative address plus value.
  typedef struct packed {
    addr_t  addr;
    pixel_t data;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_ACK,
    ACC_SETTLE
  } acc_state_t;

  typedef enum logic {
    W_IDLE,
    W_WRITE
  } wr_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - small synchronous FIFO for buffered pixel writes
// Purpose: DEPTH-entry FIFO with registered storage and a combinational view
//          of the head and the entry behind it.
// Ports:   clk, n_rst        clock, async active-low reset
//          push_i/push_data_i write an entry (ignored when full)
//          pop_i             drop the head (ignored when empty)
//          head_o, next_o    head entry and the one after it
//          full_o, empty_o   occupancy flags
//          multi_o           two or more entries held
module pixel_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 40
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [WIDTH-1:0] next_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             multi_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra bit so full and empty can be told apart.
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      count;
  logic [AW-1:0]    rd_next_idx;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign count       = wr_ptr_q - rd_ptr_q;
  assign empty_o     = (wr_ptr_q == rd_ptr_q);
  assign full_o      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign multi_o     = (count > (AW+1)'(1));
  assign rd_next_idx = rd_ptr_q[AW-1:0] + AW'(1);

  // Fullness is judged before the edge: a pop on the same edge does not
  // make room for a push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign head_o = mem_q[rd_ptr_q[AW-1:0]];
  assign next_o = mem_q[rd_next_idx];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - buffers search-stage pixels and writes them to frame memory
// Purpose: accepts {address, value} from the Julia search stage, acknowledges
//          each with a one-cycle release pulse, buffers it in pixel_fifo and
//          issues single-beat Avalon-MM writes at BASE_ADDR + address.
//          Optional frame counter: define PIXEL_WRITER_FRAME_COUNT_EN.
// Ports:   clk, n_rst                      clock, async active-low reset
//          found, sel_data_syn,
//          sel_address_syn                 selected pixel from search stage
//          release_o                       pixel accepted (one-cycle pulse)
//          avm_address, avm_writedata,
//          avm_write, avm_waitrequest      Avalon-MM write master
//          busy                            pixels buffered or write pending
//          frame_done                      last pixel of a frame written
module pixel_writer
  import julia_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned FRAME_PIXELS = 307200
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        found,
  input  logic [7:0]  sel_data_syn,
  input  logic [31:0] sel_address_syn,
  output logic        release_o,
  output logic [31:0] avm_address,
  output logic [7:0]  avm_writedata,
  output logic        avm_write,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

  acc_state_t  acc_q;
  wr_state_t   wr_q;
  logic        release_q;
  logic        avm_write_q;
  addr_t       avm_address_q;
  pixel_t      avm_writedata_q;

  fifo_entry_t push_entry;
  fifo_entry_t head_entry;
  fifo_entry_t next_entry;
  logic        fifo_push;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_multi;
  logic        wr_done;

  assign push_entry = '{addr: sel_address_syn, data: sel_data_syn};
  assign fifo_push  = (acc_q == ACC_IDLE) && found && !fifo_full;
  assign wr_done    = avm_write_q && !avm_waitrequest;

  // The entry being written stays in the FIFO until it completes, so a full
  // FIFO includes the in-flight pixel.
  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .n_rst       (n_rst),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (wr_done),
    .head_o      (head_entry),
    .next_o      (next_entry),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .multi_o     (fifo_multi)
  );

  // Accept FSM. SETTLE gives the search stage one cycle to refresh its
  // registered outputs after seeing release before found is trusted again.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q     <= ACC_IDLE;
      release_q <= 1'b0;
    end else begin
      case (acc_q)
        ACC_IDLE: begin
          release_q <= 1'b0;
          if (found && !fifo_full) acc_q <= ACC_ACK;
        end
        ACC_ACK: begin
          release_q <= 1'b1;
          acc_q     <= ACC_SETTLE;
        end
        ACC_SETTLE: begin
          release_q <= 1'b0;
          acc_q     <= ACC_IDLE;
        end
        default: begin
          release_q <= 1'b0;
          acc_q     <= ACC_IDLE;
        end
      endcase
    end
  end

  // Write FSM. On completion the entry behind the head is loaded directly so
  // a backlog drains at one write per cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_q            <= W_IDLE;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
    end else if (wr_q == W_IDLE) begin
      if (!fifo_empty) begin
        avm_address_q   <= BASE_ADDR + head_entry.addr;
        avm_writedata_q <= head_entry.data;
        avm_write_q     <= 1'b1;
        wr_q            <= W_WRITE;
      end
    end else begin
      if (!avm_waitrequest) begin
        if (fifo_multi) begin
          avm_address_q   <= BASE_ADDR + next_entry.addr;
          avm_writedata_q <= next_entry.data;
        end else begin
          avm_write_q <= 1'b0;
          wr_q        <= W_IDLE;
        end
      end
    end
  end

  assign release_o     = release_q;
  assign avm_address   = avm_address_q;
  assign avm_writedata = avm_writedata_q;
  assign avm_write     = avm_write_q;
  assign busy          = !fifo_empty || avm_write_q;

`ifdef PIXEL_WRITER_FRAME_COUNT_EN
  localparam int unsigned FC_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  logic [FC_W-1:0] frame_cnt_q;
  logic [FC_W-1:0] frame_cnt_d;
  logic            frame_done_q;
  logic            frame_done_d;

  always_comb begin
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (wr_done) begin
      if (frame_cnt_q == FC_W'(FRAME_PIXELS - 1)) begin
        frame_cnt_d  = '0;
        frame_done_d = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;
`else
  // No frame counter in this build; FRAME_PIXELS only matters when it exists.
  assign frame_done = 1'b0 & (FRAME_PIXELS == 0);
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// tb/tb_pixel_writer.sv - directed self-checking bench for pixel_writer
module tb_pixel_writer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        found = 1'b0;
  logic [7:0]  sel_data_syn = 8'h00;
  logic [31:0] sel_address_syn = 32'h0;
  logic        avm_waitrequest = 1'b0;

  logic        release_o, avm_write, busy, frame_done;
  logic [31:0] avm_address;
  logic [7:0]  avm_writedata;

  logic        release_w, avm_write_w, busy_w, frame_done_w;
  logic [31:0] avm_address_w;
  logic [7:0]  avm_writedata_w;

  pixel_writer #(
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (32'h0000_1000),
    .FRAME_PIXELS (4)
  ) dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .found           (found),
    .sel_data_syn    (sel_data_syn),
    .sel_address_syn (sel_address_syn),
    .release_o       (release_o),
    .avm_address     (avm_address),
    .avm_writedata   (avm_writedata),
    .avm_write       (avm_write),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  pixel_writer #(
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (32'h0000_0002),
    .FRAME_PIXELS (4)
  ) dut_w (
    .clk             (clk),
    .n_rst           (n_rst),
    .found           (found),
    .sel_data_syn    (sel_data_syn),
    .sel_address_syn (sel_address_syn),
    .release_o       (release_w),
    .avm_address     (avm_address_w),
    .avm_writedata   (avm_writedata_w),
    .avm_write       (avm_write_w),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy_w),
    .frame_done      (frame_done_w)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!busy) break;
    end
    check(tag, busy, 1'b0);
  endtask

  // Write log and pulse monitors, sampled on the falling edge.
  int          cyc = 0;
  int          wr_count = 0;
  logic [31:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int          wr_cyc[$];
  logic        prev_rel = 1'b0;
  int          fd_count = 0;
  int          fd_base = 0;
  logic [31:0] fd_mask = 32'h0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (n_rst && avm_write && !avm_waitrequest) begin
      wr_addr.push_back(avm_address);
      wr_data.push_back(avm_writedata);
      wr_cyc.push_back(cyc);
      wr_count++;
    end
    if (release_o) check("rel_gap", {31'd0, prev_rel}, 32'd0);
    prev_rel = release_o;
    if (frame_done) begin
      fd_count++;
      fd_mask = fd_mask | (32'd1 << (wr_count - fd_base));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  int          base;
  int          rels;
  int          idx;
  int          stable_err;
  int          ok;
  logic [9:0]  rel_bits;
  logic [31:0] exp_mask;
  int          exp_fd;

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_release", release_o, 0);
    check("rst_write", avm_write, 0);
    check("rst_addr", avm_address, 0);
    check("rst_data", avm_writedata, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    n_rst = 1'b1;
    repeat (2) tick();

    // Single pixel: release at N+1, write to 0x1010
    found = 1'b1; sel_data_syn = 8'hA5; sel_address_syn = 32'h10;
    tick();
    check("t1_release_n", release_o, 0);
    check("t1_busy_n", busy, 1);
    tick();
    check("t1_release", release_o, 1);
    check("t1_write", avm_write, 1);
    check("t1_addr", avm_address, 32'h0000_1010);
    check("t1_data", avm_writedata, 8'hA5);
    found = 1'b0;
    tick();
    check("t1_release_off", release_o, 0);
    check("t1_write_off", avm_write, 0);
    check("t1_busy_off", busy, 0);
    check("t1_count", wr_count, 1);
    repeat (3) tick();

    // found held for 10 cycles: release every 3rd cycle
    base = wr_count;
    found = 1'b1; sel_data_syn = 8'h3C; sel_address_syn = 32'h20;
    rel_bits = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rel_bits = {rel_bits[8:0], release_o};
    end
    found = 1'b0;
    check("t2_pattern", {22'd0, rel_bits}, {22'd0, 10'b0100100100});
    wait_idle("t2_idle");
    check("t2_writes", wr_count - base, 4);
    repeat (3) tick();

    // Stall: four accepts fill the FIFO, outputs hold, then drain in order
    base = wr_count;
    avm_waitrequest = 1'b1;
    idx = 0; rels = 0; stable_err = 0;
    sel_data_syn = 8'h30; sel_address_syn = 32'h100;
    found = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (release_o) begin
        rels++; idx++;
        sel_data_syn = 8'h30 + 8'(idx);
        sel_address_syn = 32'h100 + 32'(idx);
      end
      if (i >= 2 && (avm_address != 32'h1100 || avm_writedata != 8'h30 || !avm_write))
        stable_err++;
    end
    check("t3_accepts", rels, 4);
    check("t3_stable", stable_err, 0);
    check("t3_no_write", wr_count - base, 0);
    found = 1'b0;
    avm_waitrequest = 1'b0;
    wait_idle("t3_idle");
    check("t3_writes", wr_count - base, 4);
    if (wr_count - base == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("t3_data%0d", k), wr_data[base+k], 8'h30 + 8'(k));
        check($sformatf("t3_addr%0d", k), wr_addr[base+k], 32'h1100 + 32'(k));
        if (k > 0) check($sformatf("t3_b2b%0d", k), wr_cyc[base+k] - wr_cyc[base+k-1], 1);
      end
    end
    repeat (3) tick();

    // Address wrap modulo 2^32
    found = 1'b1; sel_address_syn = 32'hFFFF_FFFF; sel_data_syn = 8'h5A;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (avm_write) begin ok = 1; break; end
    end
    found = 1'b0;
    check("t4_seen", ok, 1);
    check("t4_addr", avm_address, 32'h0000_0FFF);
    check("t4_addr_wrap", avm_address_w, 32'h0000_0001);
    wait_idle("t4_idle");
    repeat (3) tick();

    // Reset mid-write with 3 entries buffered
    avm_waitrequest = 1'b1;
    rels = 0; idx = 0;
    sel_data_syn = 8'h40; sel_address_syn = 32'h200;
    found = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (release_o) begin
        rels++; idx++;
        sel_data_syn = 8'h40 + 8'(idx);
        sel_address_syn = 32'h200 + 32'(idx);
      end
      if (rels == 3) break;
    end
    found = 1'b0;
    check("t5_accepts", rels, 3);
    repeat (2) tick();
    check("t5_write_pre", avm_write, 1);
    base = wr_count;
    #2 n_rst = 1'b0;
    #1;
    check("t5_write_rst", avm_write, 0);
    check("t5_busy_rst", busy, 0);
    repeat (2) tick();
    n_rst = 1'b1;
    avm_waitrequest = 1'b0;
    repeat (10) tick();
    check("t5_no_writes", wr_count - base, 0);
    check("t5_busy_after", busy, 0);
    check("t5_write_after", avm_write, 0);

    // Frame counter: 9 pixels with FRAME_PIXELS = 4
    fd_count = 0; fd_mask = 32'h0; fd_base = wr_count;
    rels = 0; idx = 0;
    sel_data_syn = 8'h60; sel_address_syn = 32'h300;
    found = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (release_o) begin
        rels++; idx++;
        sel_data_syn = 8'h60 + 8'(idx);
        sel_address_syn = 32'h300 + 32'(idx);
      end
      if (rels == 9) break;
    end
    found = 1'b0;
    wait_idle("t6_idle");
    check("t6_accepts", rels, 9);
    check("t6_writes", wr_count - fd_base, 9);
`ifdef PIXEL_WRITER_FRAME_COUNT_EN
    exp_mask = 32'h0000_0110;
    exp_fd   = 2;
`else
    exp_mask = 32'h0;
    exp_fd   = 0;
`endif
    check("t6_fd_mask", fd_mask, exp_mask);
    check("t6_fd_count", fd_count, exp_fd);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
